// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes from long-latency producers and stalls decode on RAW/WAW hazards.
// stall/issue_fire are same-cycle; pending/busy/wb_err update on the next edge; writeback bypasses same-cycle.
module reg_scoreboard #(
    parameter int NREG = 64,
    parameter int AW   = 6,
    parameter int NVEC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic [AW-1:0]   rs0,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rs3,
    input  logic [AW-1:0]   rs4,
    input  logic [AW-1:0]   rs5,
    input  logic            issue_valid,
    input  logic            issue_vec,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   issue_vrd0,
    input  logic [AW-1:0]   issue_vrd1,
    input  logic [AW-1:0]   issue_vrd2,
    input  logic [AW-1:0]   issue_vrd3,
    input  logic            wb_valid,
    input  logic            wb_vec,
    input  logic [AW-1:0]   wb_rd,
    input  logic [AW-1:0]   wb_vrd0,
    input  logic [AW-1:0]   wb_vrd1,
    input  logic [AW-1:0]   wb_vrd2,
    input  logic [AW-1:0]   wb_vrd3,
    output logic            stall,
    output logic            issue_fire,
    output logic [NREG-1:0] pending,
    output logic            busy,
    output logic            wb_err
);

    // Register 0 is hard-wired zero, so its decode bit is always suppressed.
    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
        logic [NREG-1:0] m;
        m    = '0;
        m[a] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    logic [AW-1:0]   ivrd [4];
    logic [AW-1:0]   wvrd [4];
    logic [NREG-1:0] iss_mask;
    logic [NREG-1:0] wb_mask;
    logic [NREG-1:0] src_mask;
    logic [NREG-1:0] pend_eff;
    logic [NREG-1:0] pend_next;
    logic            raw;
    logic            waw;
    logic            err_set;

    assign ivrd[0] = issue_vrd0;
    assign ivrd[1] = issue_vrd1;
    assign ivrd[2] = issue_vrd2;
    assign ivrd[3] = issue_vrd3;
    assign wvrd[0] = wb_vrd0;
    assign wvrd[1] = wb_vrd1;
    assign wvrd[2] = wb_vrd2;
    assign wvrd[3] = wb_vrd3;

    always_comb begin
        iss_mask = '0;
        wb_mask  = '0;
        if (issue_vec) begin
            for (int i = 0; i < NVEC; i++) iss_mask = iss_mask | onehot(ivrd[i]);
        end else begin
            iss_mask = onehot(issue_rd);
        end
        if (wb_valid) begin
            if (wb_vec) begin
                for (int i = 0; i < NVEC; i++) wb_mask = wb_mask | onehot(wvrd[i]);
            end else begin
                wb_mask = onehot(wb_rd);
            end
        end
        src_mask = onehot(rs0) | onehot(rs1) | onehot(rs2)
                 | onehot(rs3) | onehot(rs4) | onehot(rs5);
    end

    // A retiring producer no longer blocks anyone: the register file supplies its value.
    assign pend_eff   = pending & ~wb_mask;
    assign raw        = |(pend_eff & src_mask);
    assign waw        = |(pend_eff & iss_mask);
    assign stall      = issue_valid && (raw || waw);
    assign issue_fire = issue_valid && !stall;
    assign err_set    = wb_valid && !clear && (|(wb_mask & ~pending));

    // Set is applied after the writeback clear so a re-issued register stays pending.
    always_comb begin
        pend_next = '0;
        if (!clear) begin
            pend_next = pending & ~wb_mask;
            if (issue_fire) pend_next = pend_next | iss_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            busy    <= 1'b0;
            wb_err  <= 1'b0;
        end else begin
            pending <= pend_next;
            busy    <= |pend_next;
            wb_err  <= wb_err | err_set;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized scoreboard bench for reg_scoreboard against a set-based reference model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear;
    logic [5:0]  rs [6];
    logic        issue_valid, issue_vec, wb_valid, wb_vec;
    logic [5:0]  issue_rd, wb_rd;
    logic [5:0]  ivrd [4];
    logic [5:0]  wvrd [4];
    logic        stall, issue_fire, busy, wb_err;
    logic [63:0] pending;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk(clk), .rst(rst), .clear(clear),
        .rs0(rs[0]), .rs1(rs[1]), .rs2(rs[2]), .rs3(rs[3]), .rs4(rs[4]), .rs5(rs[5]),
        .issue_valid(issue_valid), .issue_vec(issue_vec), .issue_rd(issue_rd),
        .issue_vrd0(ivrd[0]), .issue_vrd1(ivrd[1]), .issue_vrd2(ivrd[2]), .issue_vrd3(ivrd[3]),
        .wb_valid(wb_valid), .wb_vec(wb_vec), .wb_rd(wb_rd),
        .wb_vrd0(wvrd[0]), .wb_vrd1(wvrd[1]), .wb_vrd2(wvrd[2]), .wb_vrd3(wvrd[3]),
        .stall(stall), .issue_fire(issue_fire), .pending(pending), .busy(busy), .wb_err(wb_err)
    );

    typedef struct {
        bit          stall;
        bit          fire;
        logic [63:0] pend;
        bit          busy;
        bit          err;
    } exp_t;

    exp_t q[$];
    bit   pend_m [64];
    bit   err_m;
    int   total  = 0;
    int   passed = 0;

    function automatic bit in_wb(int r);
        if (!wb_valid) return 1'b0;
        if (wb_vec) begin
            for (int i = 0; i < 4; i++) if (int'(wvrd[i]) == r) return 1'b1;
            return 1'b0;
        end
        return int'(wb_rd) == r;
    endfunction

    function automatic bit eff(int r);
        return r != 0 && pend_m[r] && !in_wb(r);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else passed++;
    endtask

    // Called right after inputs change at a negedge; predicts this cycle, then applies the edge.
    task automatic cycle();
        exp_t e;
        bit   raw, waw;
        if (rst) begin
            foreach (pend_m[r]) pend_m[r] = 1'b0;
            err_m = 1'b0;
        end
        raw = 1'b0;
        waw = 1'b0;
        for (int i = 0; i < 6; i++) raw |= eff(int'(rs[i]));
        if (issue_vec) for (int i = 0; i < 4; i++) waw |= eff(int'(ivrd[i]));
        else waw = eff(int'(issue_rd));
        e.stall = issue_valid && (raw || waw);
        e.fire  = issue_valid && !e.stall;
        e.pend  = '0;
        for (int r = 0; r < 64; r++) e.pend[r] = pend_m[r];
        e.busy  = (e.pend != 0);
        e.err   = err_m;
        q.push_back(e);
        @(posedge clk);
        if (!rst) begin
            if (clear) begin
                foreach (pend_m[r]) pend_m[r] = 1'b0;
            end else begin
                for (int r = 1; r < 64; r++) if (in_wb(r) && !pend_m[r]) err_m = 1'b1;
                for (int r = 1; r < 64; r++) if (in_wb(r)) pend_m[r] = 1'b0;
                if (e.fire) begin
                    if (issue_vec) begin
                        for (int i = 0; i < 4; i++) if (ivrd[i] != 0) pend_m[ivrd[i]] = 1'b1;
                    end else if (issue_rd != 0) begin
                        pend_m[issue_rd] = 1'b1;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        clear = 0; issue_valid = 0; issue_vec = 0; issue_rd = 0;
        wb_valid = 0; wb_vec = 0; wb_rd = 0;
        for (int i = 0; i < 6; i++) rs[i] = 0;
        for (int i = 0; i < 4; i++) begin ivrd[i] = 0; wvrd[i] = 0; end
    endtask

    task automatic issue(logic [5:0] rd);
        idle(); issue_valid = 1; issue_rd = rd; cycle();
    endtask

    task automatic randomize_inputs();
        int pl[$];
        for (int r = 1; r < 64; r++) if (pend_m[r]) pl.push_back(r);
        clear       = ($urandom_range(0, 39) == 0);
        issue_valid = $urandom_range(0, 1);
        issue_vec   = ($urandom_range(0, 3) == 0);
        issue_rd    = 6'($urandom_range(0, 15));
        wb_valid    = ($urandom_range(0, 2) != 0);
        wb_vec      = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 6; i++) rs[i] = 6'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) ivrd[i] = 6'($urandom_range(0, 15));
        if (pl.size() > 0 && $urandom_range(0, 9) < 8) begin
            wb_rd = 6'(pl[$urandom_range(0, pl.size() - 1)]);
            for (int i = 0; i < 4; i++) wvrd[i] = 6'(pl[$urandom_range(0, pl.size() - 1)]);
        end else begin
            wb_rd = 6'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) wvrd[i] = 6'($urandom_range(0, 15));
        end
    endtask

    // Monitor: outputs are stable 2 time units after the driving negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("stall", 64'(stall), 64'(e.stall));
                check("issue_fire", 64'(issue_fire), 64'(e.fire));
                check("pending", pending, e.pend);
                check("busy", 64'(busy), 64'(e.busy));
                check("wb_err", 64'(wb_err), 64'(e.err));
            end
        end
    end

    initial begin
        idle();
        err_m = 1'b0;
        foreach (pend_m[r]) pend_m[r] = 1'b0;
        @(negedge clk);
        rst = 1;
        for (int k = 0; k < 4; k++) begin randomize_inputs(); cycle(); end
        rst = 0;
        issue(6'd5);
        idle(); cycle();
        // RAW stall, then the same request with a same-cycle writeback bypass
        idle(); issue_valid = 1; rs[0] = 5; issue_rd = 6; cycle();
        wb_valid = 1; wb_rd = 5; cycle();
        idle(); wb_valid = 1; wb_rd = 6; cycle();
        // vector issue, WAW stall, vector writeback
        idle(); issue_valid = 1; issue_vec = 1;
        ivrd[0] = 8; ivrd[1] = 9; ivrd[2] = 10; ivrd[3] = 11; cycle();
        issue(6'd10);
        idle(); wb_valid = 1; wb_vec = 1;
        wvrd[0] = 8; wvrd[1] = 9; wvrd[2] = 10; wvrd[3] = 11; cycle();
        idle(); cycle();
        // same-cycle writeback and re-issue of register 7
        issue(6'd7);
        idle(); issue_valid = 1; issue_rd = 7; wb_valid = 1; wb_rd = 7; cycle();
        idle(); cycle();
        // zero register and sticky writeback error
        issue(6'd0);
        idle(); wb_valid = 1; wb_rd = 12; cycle();
        idle(); cycle();
        idle(); cycle();
        // clear beats a firing issue; wb_err survives clear
        issue(6'd3);
        issue(6'd4);
        idle(); clear = 1; issue_valid = 1; issue_rd = 6; cycle();
        idle(); cycle();
        // asynchronous reset mid-operation
        issue(6'd9);
        idle(); rst = 1; cycle();
        rst = 0; cycle();
        for (int k = 0; k < 3000; k++) begin
            randomize_inputs();
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 0;
        idle();
        repeat (3) @(negedge clk);
        #5;
        total++;
        if (q.size() != 0) $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks outstanding register writes from multi-cycle producers (loads, FPU, vector loads) across the 64-entry unified scalar/vector register space (6-bit addresses).
- Sits beside the decode stage. Decode presents source and destination addresses; the block answers with an issue stall.
- When issue is accepted, the block marks destinations pending. Writeback of a producer clears the pending mark.
- It complements the combinational forwarding/stall logic by covering producers whose latency exceeds the forwarding window.

Parameters:
NREG, 64, number of tracked registers; address 0 is hard-wired zero and is never pending
AW, 6, register address width
NVEC, 4, destination registers written by one vector instruction

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
clear  in  1  synchronous clear of all pending state (pipeline flush / trap)
rs0..rs5  in  AW each  decode source addresses; rs0/rs1 scalar, rs2..rs5 vector lanes; 0 = unused
issue_valid  in  1  decode has a long-latency instruction wanting to issue
issue_vec  in  1  1: destinations are issue_vrd0..3; 0: destination is issue_rd
issue_rd  in  AW  scalar destination
issue_vrd0..issue_vrd3  in  AW each  vector destinations
wb_valid  in  1  a tracked producer completes this cycle
wb_vec  in  1  1: clear wb_vrd0..3; 0: clear wb_rd
wb_rd  in  AW  scalar writeback destination
wb_vrd0..wb_vrd3  in  AW each  vector writeback destinations
stall  out  1  combinational; decode must hold
issue_fire  out  1  combinational; issue_valid && !stall
pending  out  NREG  registered pending bitmap; bit 0 is always 0
busy  out  1  registered; |pending
wb_err  out  1  sticky; writeback to a register that is not pending

Behaviour:
- Reset (async, rst=1): pending=0, busy=0, wb_err=0. Release is synchronous to clk.
- A source or destination address of 0 never matches and is never set.
- Effective pending for hazard checks is pend_eff[r] = pending[r] && !(wb_valid && r is one of this cycle's wb destinations). Same-cycle writeback therefore bypasses; the register file supplies the value.
- RAW: raw = OR over rs0..rs5 of pend_eff[rs].
- WAW: waw = OR over this cycle's issue destinations of pend_eff[d]. There is only one outstanding write per register, so a single bit per register suffices.
- stall = issue_valid && (raw || waw). When issue_valid=0, stall=0.
- Next state, per bit r, in this priority order:
  - clear=1 gives pending_next=0, and this takes priority over everything else.
  - Otherwise a bit is set if issue_fire and r is an issue destination.
  - Otherwise a bit is cleared if wb_valid and r is a wb destination.
  - Otherwise the bit holds.
  - If set and clear hit the same r in the same cycle, set wins and the register stays pending for the new producer.
- Duplicate addresses within issue_vrd0..3 or wb_vrd0..3 are legal and behave idempotently.
- wb_err is set on a clock edge where wb_valid=1, clear=0, and some nonzero wb destination has pending[r]=0 before the update. It holds until rst; clear does not reset it.
- busy is updated on the same edge as pending and reflects the post-update bitmap.
- Latency: stall and issue_fire are same-cycle. A pending set is visible on the next cycle. A pending clear takes effect for hazard checks in the same cycle through the bypass.
- Reset asserted mid-operation discards all pending state immediately (asynchronously). After release there are no stalls.
- Implementation: flat NREG-bit register, one-hot decode of each address, no counters. Expected size is roughly 150-250 lines.

Test Plan:
- Reset: drive rst=1 with random inputs -> pending=0, busy=0, wb_err=0, stall=0. Then release, issue_valid=1, issue_rd=5 -> issue_fire=1; next cycle pending[5]=1, busy=1.
- RAW stall and bypass: pending[5]=1, rs0=5, issue_valid=1 -> stall=1. Repeat with wb_valid=1, wb_rd=5 in the same cycle -> stall=0, issue_fire=1.
- Vector issue/WAW: issue_vec=1, vrd=8,9,10,11 -> pending[11:8]=4'hF. Next issue_rd=10 -> stall=1. wb_vec=1, wb_vrd=8..11 -> pending=0, busy=0.
- Same-cycle set/clear: pending[7]=1, wb_rd=7 and issue_rd=7 fire together -> pending[7] remains 1, wb_err=0.
- Zero register and wb_err: issue_rd=0 -> pending unchanged, stall=0. wb_valid=1, wb_rd=12 with pending[12]=0 -> wb_err=1 next cycle and stays 1.
- Clear priority: pending={3,4}, clear=1 with issue_rd=6 firing -> next cycle pending=0, busy=0.
